// File: rtl/aes_128_pkg.sv
// rtl/aes_128_pkg.sv - shared widths, defaults and requester IDs for the AES-128 scheduler
package aes_128_pkg;

  localparam int AES_BLK_W     = 128;
  localparam int AES_ISSUE_GAP = 4;
  localparam int AES_TAG_DEPTH = 4;

  typedef logic req_id_t;

  localparam req_id_t REQ_ID0 = 1'b0;
  localparam req_id_t REQ_ID1 = 1'b1;

endpackage

// File: rtl/aes_128_tag_fifo.sv
// rtl/aes_128_tag_fifo.sv - in-order requester-ID FIFO for blocks in flight through the core
module aes_128_tag_fifo
  import aes_128_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  req_id_t                  push_id,
  input  logic                     pop,
  output req_id_t                  pop_id,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  req_id_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_id  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry contents are meaningless until pushed, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/aes_128_req_sched.sv
// rtl/aes_128_req_sched.sv - round-robin, gap-enforcing issue scheduler sharing one AES-128 core
module aes_128_req_sched
  import aes_128_pkg::*;
#(
  parameter int ISSUE_GAP = AES_ISSUE_GAP,
  parameter int TAG_DEPTH = AES_TAG_DEPTH
) (
  input  logic                 clk,
  input  logic                 kill_n,
  input  logic [AES_BLK_W-1:0] req0_data,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [AES_BLK_W-1:0] req1_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 key_ready,
  output logic [AES_BLK_W-1:0] core_in_data,
  output logic                 core_in_en,
  input  logic [AES_BLK_W-1:0] core_out_data,
  input  logic                 core_out_en,
  output logic [AES_BLK_W-1:0] rsp0_data,
  output logic                 rsp0_valid,
  output logic [AES_BLK_W-1:0] rsp1_data,
  output logic                 rsp1_valid,
  output logic                 busy,
  output logic                 tag_err_pulse
);

  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] inflight;
  req_id_t          last;
  req_id_t          grant;
  req_id_t          head_id;
  logic             fifo_empty;
  logic             fifo_full;
  logic             xfer;
  logic             pop;

  always_comb begin
    grant = REQ_ID0;
    if (req0_valid && req1_valid) grant = ~last;
    else if (req1_valid)          grant = REQ_ID1;
  end

  // kill_n gates the grant so nothing is accepted while reset is held.
  assign xfer       = kill_n & key_ready & (gap_cnt == '0) & ~fifo_full & (req0_valid | req1_valid);
  assign req0_ready = xfer & (grant == REQ_ID0);
  assign req1_ready = xfer & (grant == REQ_ID1);
  assign pop        = core_out_en & ~fifo_empty;
  assign busy       = (inflight != '0) | core_in_en;

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      core_in_data <= '0;
      core_in_en   <= 1'b0;
      gap_cnt      <= '0;
      last         <= REQ_ID1;
    end else begin
      core_in_en <= xfer;
      if (xfer) begin
        core_in_data <= (grant == REQ_ID1) ? req1_data : req0_data;
        last         <= grant;
        gap_cnt      <= GAP_W'(ISSUE_GAP - 1);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  // Results come back in issue order, so the FIFO head always names the owner.
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      rsp0_data     <= '0;
      rsp0_valid    <= 1'b0;
      rsp1_data     <= '0;
      rsp1_valid    <= 1'b0;
      tag_err_pulse <= 1'b0;
    end else begin
      rsp0_valid    <= pop & (head_id == REQ_ID0);
      rsp1_valid    <= pop & (head_id == REQ_ID1);
      tag_err_pulse <= core_out_en & fifo_empty;
      if (pop && head_id == REQ_ID0) rsp0_data <= core_out_data;
      if (pop && head_id == REQ_ID1) rsp1_data <= core_out_data;
    end
  end

  aes_128_tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clk    (clk),
    .rst_n  (kill_n),
    .push   (xfer),
    .push_id(grant),
    .pop    (pop),
    .pop_id (head_id),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (inflight)
  );

endmodule
